// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU op sequencer.
package alu_seq_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PASS1 = 2'd1,
    S_PASS2 = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // Macro opcodes (0x0-0x7 map straight onto an ALU op)
  localparam logic [3:0] OP_LDI = 4'd8;
  localparam logic [3:0] OP_SUB = 4'd9;
  localparam logic [3:0] OP_NOP = 4'd10;

  // ALU op selects
  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_INC  = 3'b001;
  localparam logic [2:0] ALU_NEGA = 3'b010;
  localparam logic [2:0] ALU_NEGB = 3'b011;

  // Anything above NOP is unassigned
  function automatic logic is_illegal(input logic [3:0] op);
    return op > OP_NOP;
  endfunction

endpackage

// File: rtl/alu_seq_regfile.sv
// NREGS x WIDTH register file: one sync write port, two operand reads, one debug read.
module alu_seq_regfile #(
  parameter int WIDTH = 4,
  parameter int NREGS = 4,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr_a,
  output logic [WIDTH-1:0] rdata_a,
  input  logic [AW-1:0]    raddr_b,
  output logic [WIDTH-1:0] rdata_b,
  input  logic [AW-1:0]    dbg_addr,
  output logic [WIDTH-1:0] dbg_data
);

  logic [NREGS-1:0][WIDTH-1:0] rf;

  // Storage: cleared on reset, single write per cycle
  always_ff @(posedge clk) begin
    if (reset) rf <= '0;
    else if (we) rf[waddr] <= wdata;
  end

  assign rdata_a  = rf[raddr_a];
  assign rdata_b  = rf[raddr_b];
  assign dbg_data = rf[dbg_addr];

endmodule

// File: rtl/alu_op_sequencer.sv
// Sequences an external combinational ALU from a macro-command stream.
// SUB is expanded into NEGB then ADD through a scratch register.
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int NREGS = 4,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [3:0]       cmd_op,
  input  logic [AW-1:0]    cmd_dst,
  input  logic [AW-1:0]    cmd_srca,
  input  logic [AW-1:0]    cmd_srcb,
  input  logic [WIDTH-1:0] cmd_imm,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_op,
  input  logic [WIDTH-1:0] alu_r,
  input  logic             alu_cout,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             flag_z,
  output logic             flag_c,
  output logic             err,
  input  logic [AW-1:0]    dbg_addr,
  output logic [WIDTH-1:0] dbg_data
);

  state_t           state, nstate;
  logic [3:0]       c_op;
  logic [AW-1:0]    c_dst, c_srca, c_srcb;
  logic [WIDTH-1:0] c_imm, tmp;
  logic [WIDTH-1:0] rdata_a, rdata_b, wdata;
  logic             we, wc, tmp_we, xfer;

  assign cmd_ready = (state == S_IDLE);
  assign xfer      = cmd_valid & cmd_ready;
  assign done      = (state == S_DONE);
  assign err       = done & is_illegal(c_op);

  alu_seq_regfile #(.WIDTH(WIDTH), .NREGS(NREGS), .AW(AW)) u_rf (
    .clk      (clk),
    .reset    (reset),
    .we       (we),
    .waddr    (c_dst),
    .wdata    (wdata),
    .raddr_a  (c_srca),
    .rdata_a  (rdata_a),
    .raddr_b  (c_srcb),
    .rdata_b  (rdata_b),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

  // Next state, ALU drive and writeback selection
  always_comb begin
    nstate = state;
    alu_a  = '0;
    alu_b  = '0;
    alu_op = ALU_ADD;
    we     = 1'b0;
    wdata  = alu_r;
    wc     = alu_cout;
    tmp_we = 1'b0;
    case (state)
      S_IDLE: begin
        // ALU ops, LDI and SUB need a pass; NOP/illegal retire immediately
        if (cmd_valid) nstate = (cmd_op <= OP_SUB) ? S_PASS1 : S_DONE;
      end
      S_PASS1: begin
        alu_a = rdata_a;
        alu_b = rdata_b;
        if (c_op == OP_SUB) begin
          alu_op = ALU_NEGB;
          tmp_we = 1'b1;
          nstate = S_PASS2;
        end else begin
          alu_op = c_op[2:0];
          we     = 1'b1;
          nstate = S_DONE;
          if (c_op == OP_LDI) begin
            wdata = c_imm;
            wc    = 1'b0;
          end
        end
      end
      S_PASS2: begin
        // srca is re-read here; dst is only written at the end of this pass
        alu_a  = rdata_a;
        alu_b  = tmp;
        alu_op = ALU_ADD;
        we     = 1'b1;
        nstate = S_DONE;
      end
      S_DONE:  nstate = S_IDLE;
      default: nstate = S_IDLE;
    endcase
  end

  // State, latched command, scratch and flag registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= S_IDLE;
      c_op   <= '0;
      c_dst  <= '0;
      c_srca <= '0;
      c_srcb <= '0;
      c_imm  <= '0;
      tmp    <= '0;
      result <= '0;
      flag_z <= 1'b1;
      flag_c <= 1'b0;
    end else begin
      state <= nstate;
      if (xfer) begin
        c_op   <= cmd_op;
        c_dst  <= cmd_dst;
        c_srca <= cmd_srca;
        c_srcb <= cmd_srcb;
        c_imm  <= cmd_imm;
      end
      if (tmp_we) tmp <= alu_r;
      if (we) begin
        result <= wdata;
        flag_z <= (wdata == '0);
        flag_c <= wc;
      end
    end
  end

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
- Controller that sequences the shared 4-bit ALU (preprocess + adder + logic stage) from a command stream.
- Owns a small register file, issues ALU passes and writes results back.
- Expands SUB into two ALU passes: negate B, then add.
- Sits between the command source and the combinational ALU; the ALU itself stays outside this block.

Parameters:
- WIDTH, 4, datapath width; must match the ALU operand width.
- NREGS, 4, register-file depth; address width is clog2(NREGS) = 2.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  block can accept a command (IDLE only).
- cmd_op  input  4  macro opcode (see Behaviour).
- cmd_dst  input  2  destination register.
- cmd_srca  input  2  source register A.
- cmd_srcb  input  2  source register B.
- cmd_imm  input  WIDTH  immediate for LDI.
- alu_a  output  WIDTH  ALU operand A.
- alu_b  output  WIDTH  ALU operand B.
- alu_op  output  3  ALU Op select.
- alu_r  input  WIDTH  ALU result (combinational from alu_a/alu_b/alu_op).
- alu_cout  input  1  ALU carry out.
- done  output  1  one-cycle pulse: command retired.
- result  output  WIDTH  value written by the last command; holds until the next write.
- flag_z  output  1  zero flag of the last write.
- flag_c  output  1  carry flag of the last write.
- err  output  1  one-cycle pulse: illegal opcode retired.
- dbg_addr  input  2  register-file debug read address.
- dbg_data  output  WIDTH  rf[dbg_addr], combinational.

Behaviour:
- Opcodes:
  - 0x0-0x7: single ALU pass, alu_op = cmd_op[2:0].
  - 0x8: LDI, rf[dst] <= imm; no ALU pass.
  - 0x9: SUB, rf[dst] <= rf[srca] - rf[srcb].
  - 0xA: NOP.
  - 0xB-0xF: illegal.
- ALU Op meaning (fixed): 000 A+B, 001 A+1, 010 -A, 011 -B, 1xx logic ops.
- FSM states: IDLE, PASS1, PASS2, DONE.
- Handshake: cmd_ready = 1 only in IDLE. A transfer is cmd_valid & cmd_ready. All cmd_* fields are latched on transfer; later changes to the inputs are ignored.
- IDLE + transfer:
  - ALU op, LDI or SUB -> PASS1.
  - NOP or illegal -> DONE directly.
- PASS1:
  - Drive alu_a = rf[srca], alu_b = rf[srcb], alu_op = latched op.
  - SUB: alu_op = 011; capture alu_r into scratch register tmp; -> PASS2.
  - Single-pass op: write rf[dst] = alu_r, result = alu_r, flag_c = alu_cout; -> DONE.
  - LDI: write rf[dst] = imm, result = imm, flag_c = 0; ALU outputs are don't-care; -> DONE.
- PASS2 (SUB only):
  - alu_a = rf[srca], alu_b = tmp, alu_op = 000.
  - Write rf[dst] = alu_r, result = alu_r, flag_c = alu_cout; -> DONE.
- DONE:
  - done = 1 for exactly one cycle.
  - err = 1 in the same cycle if the opcode was illegal.
  - -> IDLE.
- flag_z = (written value == 0). flag_z is updated on every write; NOP and illegal leave result and flags unchanged.
- Latency from the transfer edge:
  - single-pass / LDI: done in cycle N+2.
  - SUB: done in cycle N+3.
  - NOP / illegal: done in cycle N+1.
  - Next accept is possible in the cycle after DONE.
- In IDLE and DONE: alu_a = alu_b = 0, alu_op = 000.
- Operand hazards:
  - srca is re-read in PASS2; dst is written only at the end of the final pass, so dst == srca or dst == srcb is safe.
  - srca == srcb on SUB yields 0, flag_z = 1.
- Arithmetic wraps modulo 2^WIDTH. Carry is passed through from the ALU, never computed here.
- Reset (synchronous, any state, including mid-SUB):
  - state = IDLE, all rf = 0, tmp = 0, result = 0.
  - flag_z = 1, flag_c = 0, done = 0, err = 0.
  - The aborted command produces no write and no done.
- cmd_valid while cmd_ready = 0: no effect; the source must hold the command.

Decomposition:
- Package alu_seq_pkg holds:
  - FSM state encoding.
  - Macro opcode constants: OP_LDI = 8, OP_SUB = 9, OP_NOP = 10.
  - ALU Op constants: ALU_ADD = 000, ALU_INC = 001, ALU_NEGA = 010, ALU_NEGB = 011.
- One sub-module: alu_seq_regfile, an NREGS x WIDTH array with one synchronous write port, two combinational operand read ports and one debug read port, cleared on reset.

Test Plan:
- Reset, then LDI r1 = 5 and LDI r2 = 3 -> each gives done at N+2, result 5 then 3, dbg_data(r1) = 5, flag_z = 0.
- ADD (op 0x0) r0 = r1 + r2 -> alu_op = 000 in PASS1, result 8, flag_c = 0; repeat with r1 = 9, r2 = 9 -> result 2, flag_c = 1.
- SUB r3 = r1 - r2 (5, 3) -> PASS1 alu_op = 011, PASS2 alu_op = 000 with alu_b = 0xD, result 2, done at N+3; SUB r1 = r1 - r1 -> result 0, flag_z = 1.
- Hold cmd_valid high with varying fields during a SUB -> cmd_ready = 0 throughout, the only accept is in IDLE, no extra writes occur.
- Opcode 0xC -> done and err in cycle N+1, rf/result/flags unchanged; NOP -> done, no err.
- Assert reset during PASS2 of a SUB -> next cycle state IDLE, all rf = 0, result = 0, flag_z = 1, no done pulse, cmd_ready = 1.
